operand_stream_feeder: RTL and testbench

- Transmit side of the u/v operand-stream interface consumed by the inner-product and systolic PE blocks.
- Holds two LEN-entry operand vectors (U, V), loaded through a simple write port.
- On start, emits U and V as valid-qualified streams (u_in/u_valid, v_in/v_valid on the consumer).
- V optionally lags U by SKEW cycles, giving the diagonal skew systolic arrays need.

---
 rtl/feeder_pkg.sv | 11 +
 rtl/stream_delay_line.sv | 32 +++
 rtl/operand_stream_feeder.sv | 125 ++++++++++++
 tb/tb_operand_stream_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared constants and FSM state encoding for the operand stream feeder.
package feeder_pkg;
   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_LEN   = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;
endpackage

// File: rtl/stream_delay_line.sv
// Delays a {valid, data} pair by DEPTH register stages; DEPTH=0 is a wire.
module stream_delay_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign out_valid = in_valid;
         assign out_data  = in_data;
      end else begin : g_pipe
         logic [WIDTH:0] pipe [DEPTH];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= {in_valid, in_data};
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign {out_valid, out_data} = pipe[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/operand_stream_feeder.sv
// Buffers U/V operand vectors and streams them out on start; V lags U by SKEW cycles.
module operand_stream_feeder
   import feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN   = DEFAULT_LEN,
   parameter int SKEW  = 0,
   parameter int AW    = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] u_out,
   output logic             u_valid,
   output logic [WIDTH-1:0] v_out,
   output logic             v_valid
);
   localparam int CW = $clog2(LEN + 1);
   localparam int DW = (SKEW > 1) ? $clog2(SKEW) : 1;

   state_t           state;
   logic [WIDTH-1:0] u_buf [LEN];
   logic [WIDTH-1:0] v_buf [LEN];
   logic [CW-1:0]    idx;
   logic [DW-1:0]    dcnt;
   logic             v_raw_valid;
   logic [WIDTH-1:0] v_raw;
   logic             wr_ok;
   logic [WIDTH-1:0] u_first;
   logic [WIDTH-1:0] v_first;

   assign wr_ok = wr_en && (state == IDLE) && (int'(wr_addr) < LEN);

   // Element 0 is read on the start edge, so a same-cycle write must bypass the buffer.
   always_comb begin
      u_first = u_buf[0];
      v_first = v_buf[0];
      if (wr_ok && wr_addr == '0) begin
         if (wr_sel) v_first = wr_data;
         else        u_first = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         u_valid     <= 1'b0;
         u_out       <= '0;
         v_raw_valid <= 1'b0;
         v_raw       <= '0;
         idx         <= '0;
         dcnt        <= '0;
         for (int i = 0; i < LEN; i++) begin
            u_buf[i] <= '0;
            v_buf[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (wr_ok) begin
            if (wr_sel) v_buf[wr_addr] <= wr_data;
            else        u_buf[wr_addr] <= wr_data;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= STREAM;
                  busy        <= 1'b1;
                  u_valid     <= 1'b1;
                  u_out       <= u_first;
                  v_raw_valid <= 1'b1;
                  v_raw       <= v_first;
                  idx         <= CW'(1);
               end
            end
            STREAM: begin
               if (idx == CW'(LEN)) begin
                  u_valid     <= 1'b0;
                  u_out       <= '0;
                  v_raw_valid <= 1'b0;
                  v_raw       <= '0;
                  if (SKEW == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                     dcnt  <= '0;
                  end
               end else begin
                  u_out <= u_buf[idx[AW-1:0]];
                  v_raw <= v_buf[idx[AW-1:0]];
                  idx   <= idx + CW'(1);
               end
            end
            DRAIN: begin
               if (dcnt == DW'(SKEW - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   stream_delay_line #(.WIDTH(WIDTH), .DEPTH(SKEW)) u_v_skew (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_raw_valid),
      .in_data   (v_raw),
      .out_valid (v_valid),
      .out_data  (v_out)
   );
endmodule

// File: tb/tb_operand_stream_feeder.sv
// Directed bench for operand_stream_feeder: one SKEW=0 and one SKEW=2 instance on shared write port.
module tb_operand_stream_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic        wr_sel = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        start0 = 1'b0;
   logic        start2 = 1'b0;

   logic        busy0, done0, u_valid0, v_valid0;
   logic [31:0] u_out0, v_out0;
   logic        busy2, done2, u_valid2, v_valid2;
   logic [31:0] u_out2, v_out2;

   int passed = 0;
   int total  = 0;
   logic        acc_clr = 1'b1;
   logic [31:0] acc = '0;

   always #5 clk = ~clk;

   operand_stream_feeder #(.WIDTH(32), .LEN(3), .SKEW(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start0), .busy(busy0), .done(done0),
      .u_out(u_out0), .u_valid(u_valid0), .v_out(v_out0), .v_valid(v_valid0)
   );

   operand_stream_feeder #(.WIDTH(32), .LEN(3), .SKEW(2)) dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start2), .busy(busy2), .done(done2),
      .u_out(u_out2), .u_valid(u_valid2), .v_out(v_out2), .v_valid(v_valid2)
   );

   // Stand-in for a downstream 3-element inner product on the SKEW=0 streams.
   always @(negedge clk) begin
      if (acc_clr)                  acc <= '0;
      else if (u_valid0 && v_valid0) acc <= acc + u_out0 * v_out0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [1:0] addr, input logic [31:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic chk_quiet0(input string tag);
      chk({tag, "_u_valid"}, {31'd0, u_valid0}, 32'd0);
      chk({tag, "_u_out"},   u_out0, 32'd0);
      chk({tag, "_v_valid"}, {31'd0, v_valid0}, 32'd0);
      chk({tag, "_v_out"},   v_out0, 32'd0);
      chk({tag, "_busy"},    {31'd0, busy0}, 32'd0);
      chk({tag, "_done"},    {31'd0, done0}, 32'd0);
   endtask

   logic [31:0] u_exp [3];
   logic [31:0] uv_exp;

   initial begin
      // Reset state
      tick();
      chk_quiet0("reset");
      chk("reset_busy2", {31'd0, busy2}, 32'd0);
      rst = 1'b1;
      tick();

      // Start with empty buffers: zeros with valids high
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk("empty_u_valid", {31'd0, u_valid0}, 32'd1);
         chk("empty_v_valid", {31'd0, v_valid0}, 32'd1);
         chk("empty_u_out", u_out0, 32'd0);
         chk("empty_v_out", v_out0, 32'd0);
         tick();
      end
      chk("empty_done", {31'd0, done0}, 32'd1);
      tick();

      // Load U={1,2,3}, V={4,5,6}; an out-of-range address must be dropped
      wr(1'b0, 2'd0, 32'd1); wr(1'b0, 2'd1, 32'd2); wr(1'b0, 2'd2, 32'd3);
      wr(1'b1, 2'd0, 32'd4); wr(1'b1, 2'd1, 32'd5); wr(1'b1, 2'd2, 32'd6);
      wr(1'b0, 2'd3, 32'd55);
      wr(1'b1, 2'd3, 32'd66);

      // SKEW=0 stream with inner product
      acc_clr = 1'b0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk("s0_u_valid", {31'd0, u_valid0}, 32'd1);
         chk("s0_u_out", u_out0, 32'(c));
         chk("s0_v_valid", {31'd0, v_valid0}, 32'd1);
         chk("s0_v_out", v_out0, 32'(c + 3));
         chk("s0_busy", {31'd0, busy0}, 32'd1);
         chk("s0_done", {31'd0, done0}, 32'd0);
         tick();
      end
      chk("s0_done_c4", {31'd0, done0}, 32'd1);
      chk("s0_busy_c4", {31'd0, busy0}, 32'd0);
      chk("s0_u_valid_c4", {31'd0, u_valid0}, 32'd0);
      chk("inner_product", acc, 32'd32);
      acc_clr = 1'b1;
      tick();

      // SKEW=2 stream
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk("s2_u_valid", {31'd0, u_valid2}, (c <= 3) ? 32'd1 : 32'd0);
         chk("s2_u_out",   u_out2, (c <= 3) ? 32'(c) : 32'd0);
         chk("s2_v_valid", {31'd0, v_valid2}, (c >= 3 && c <= 5) ? 32'd1 : 32'd0);
         chk("s2_v_out",   v_out2, (c >= 3 && c <= 5) ? 32'(c + 1) : 32'd0);
         chk("s2_busy",    {31'd0, busy2}, (c <= 5) ? 32'd1 : 32'd0);
         chk("s2_done",    {31'd0, done2}, (c == 6) ? 32'd1 : 32'd0);
         tick();
      end

      // Write during busy is dropped
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("wb_c1_u", u_out0, 32'd1);
      tick();
      chk("wb_c2_u", u_out0, 32'd2);
      wr(1'b0, 2'd1, 32'd99);
      chk("wb_c3_u", u_out0, 32'd3);
      tick();
      chk("wb_c4_done", {31'd0, done0}, 32'd1);
      tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick();
      chk("wb_next_u1", u_out0, 32'd2);
      tick();
      tick();
      tick();

      // Write+start same cycle, then start held for 12 cycles
      u_exp[0] = 32'd7; u_exp[1] = 32'd2; u_exp[2] = 32'd3;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 32'd7;
      start0 = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("ws_first_u", u_out0, 32'd7);
      chk("ws_first_v", v_out0, 32'd4);
      for (int c = 1; c <= 12; c++) begin
         uv_exp = ((c % 4) != 0) ? 32'd1 : 32'd0;
         chk("held_u_valid", {31'd0, u_valid0}, uv_exp);
         chk("held_u_out", u_out0, (uv_exp != 0) ? u_exp[(c - 1) % 4] : 32'd0);
         chk("held_busy", {31'd0, busy0}, uv_exp);
         chk("held_done", {31'd0, done0}, ((c % 4) == 0) ? 32'd1 : 32'd0);
         if (c < 12) tick();
      end
      start0 = 1'b0;
      tick();
      tick();

      // Held start with reset in cycle 6
      start0 = 1'b1;
      for (int c = 1; c <= 5; c++) tick();
      tick();
      chk("rs_c6_u_valid", {31'd0, u_valid0}, 32'd1);
      chk("rs_c6_u_out", u_out0, 32'd2);
      start0 = 1'b0;
      wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3)); wr_data = $urandom;
      rst = 1'b0;
      #1;
      chk_quiet0("rs_async");
      tick();
      wr_en = 1'b0;
      rst = 1'b1;
      tick();
      chk("rs_c8_done", {31'd0, done0}, 32'd0);
      chk("rs_c8_u_valid", {31'd0, u_valid0}, 32'd0);

      // Buffers are zeroed by reset
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("rs_buf_u_valid", {31'd0, u_valid0}, 32'd1);
      chk("rs_buf_u_out", u_out0, 32'd0);
      chk("rs_buf_v_out", v_out0, 32'd0);
      tick();
      tick();
      tick();
      chk("rs_buf_done", {31'd0, done0}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
